uart_line_echo: RTL and testbench

UART_LINE_ECHO -- requirements
Module: uart_line_echo

---
 rtl/uart_line_echo.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_line_echo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_echo.sv
// uart_line_echo: buffers a CR-terminated line from a UART receiver and retransmits it in order.
// Optional macro UART_ECHO_CRLF_EN appends a 0x0A after each echoed line (adds the SEND_LF state).

module uart_line_echo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       busy,
    output logic       overflow
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [7:0]  CR_BYTE    = 8'h0D;
    localparam logic [AW:0] FILL_LIMIT = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ZERO   = {(AW + 1){1'b0}};
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef UART_ECHO_CRLF_EN
    localparam logic [7:0] LF_BYTE = 8'h0A;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SEND    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_SEND_LF = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SEND    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;
`endif

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    hold_byte_r;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          fifo_empty_s;
    logic          tx_en_s;
    logic          busy_s;
    logic [7:0]    tx_data_r;
    logic          tx_en_r;
    logic          busy_r;
    logic          overflow_r;
`ifdef UART_ECHO_CRLF_EN
    logic          load_lf_s;
    logic          lf_done_r;
`endif

    assign fifo_empty_s = (count_r == CNT_ZERO);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and FIFO push/pop/drop decisions
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        drop_s  = 1'b0;
`ifdef UART_ECHO_CRLF_EN
        load_lf_s = 1'b0;
`endif
        case (state_r)
            ST_COLLECT: begin
                if (rx_valid) begin
                    if (rx_data == CR_BYTE) begin
                        push_s  = 1'b1;
                        state_s = ST_SEND;
                    end else if (count_r < FILL_LIMIT) begin
                        // The last slot stays reserved for the terminating CR
                        push_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_SEND: begin
                drop_s = rx_valid;
                if (fifo_empty_s) begin
`ifdef UART_ECHO_CRLF_EN
                    state_s = ST_SEND_LF;
`else
                    state_s = ST_COLLECT;
`endif
                end else if (tx_rdy) begin
                    pop_s   = 1'b1;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_HOLD: begin
                drop_s = rx_valid;
`ifdef UART_ECHO_CRLF_EN
                if (lf_done_r) begin
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_SEND;
                end
`else
                state_s = ST_SEND;
`endif
            end
`ifdef UART_ECHO_CRLF_EN
            ST_SEND_LF: begin
                drop_s = rx_valid;
                if (tx_rdy) begin
                    load_lf_s = 1'b1;
                    state_s   = ST_HOLD;
                end else begin
                    state_s = ST_SEND_LF;
                end
            end
`endif
            default: begin
                state_s = ST_COLLECT;
            end
        endcase
    end

    // Output decode: a transmit pulse is issued for the cycle after each HOLD
    always_comb begin
        tx_en_s = (state_r == ST_HOLD);
        busy_s  = (state_s != ST_COLLECT);
    end

    // Line buffer storage; left without reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // FIFO pointers, occupancy and the byte staged for the next transmit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            hold_byte_r <= 8'h00;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                hold_byte_r <= mem_r[rd_ptr_r];
            end
`ifdef UART_ECHO_CRLF_EN
            else if (load_lf_s) begin
                rd_ptr_r    <= rd_ptr_r;
                hold_byte_r <= LF_BYTE;
            end
`endif
            else begin
                rd_ptr_r    <= rd_ptr_r;
                hold_byte_r <= hold_byte_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef UART_ECHO_CRLF_EN
    // Marks that the trailing line feed has been staged, so HOLD returns to COLLECT
    always_ff @(posedge clk) begin
        if (rst) begin
            lf_done_r <= 1'b0;
        end else if (load_lf_s) begin
            lf_done_r <= 1'b1;
        end else if (state_s == ST_COLLECT) begin
            lf_done_r <= 1'b0;
        end else begin
            lf_done_r <= lf_done_r;
        end
    end
`endif

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Registered transmit interface; tx_data only changes together with a tx_en pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            tx_en_r <= tx_en_s;
            busy_r  <= busy_s;
            if (tx_en_s) begin
                tx_data_r <= hold_byte_r;
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_en    = tx_en_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo: directed lines plus randomized lines and tx_rdy,
// checked against a line-level reference model (honours UART_ECHO_CRLF_EN).

module tb_uart_line_echo;

    localparam int DEPTH   = 16;
    localparam int BUDGET  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_rdy;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;
    logic       overflow;

    logic       rdy_force = 1'b1;
    logic       rdy_rand = 1'b0;
    logic       rnd_bit = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_edge = 0;

    logic [7:0] obs_q[$];
    int         en_cyc_q[$];
    int         en_total = 0;
    int         consec_err = 0;
    int         stab_err = 0;
    logic       prev_en = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       exp_ovf = 1'b0;

    uart_line_echo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_rdy   (tx_rdy),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign tx_rdy = rdy_rand ? rnd_bit : rdy_force;

    // Transmit monitor: records echoed bytes and protocol violations
    always @(negedge clk) begin
        if (rst) begin
            prev_en   = 1'b0;
            last_data = tx_data;
        end else begin
            if (tx_en) begin
                obs_q.push_back(tx_data);
                en_cyc_q.push_back(cyc);
                en_total++;
                if (prev_en) consec_err++;
            end else if (tx_data !== last_data) begin
                stab_err++;
            end
            prev_en   = tx_en;
            last_data = tx_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "/idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // mode 0: tx_rdy high + latency check; 1: random tx_rdy; 2: tx_rdy low 50 cycles with injected byte
    task automatic run_line(input string tag, input logic [7:0] line[$], input int mode);
        logic [7:0] exp_q[$];
        int cr_edge;
        int base;
        int rdy_edge;
        obs_q.delete();
        en_cyc_q.delete();
        foreach (line[i]) begin
            if (line[i] == 8'h0D) exp_q.push_back(line[i]);
            else if (exp_q.size() < DEPTH - 1) exp_q.push_back(line[i]);
            else exp_ovf = 1'b1;
        end
`ifdef UART_ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        rdy_rand = (mode == 1);
        if (mode == 2) rdy_force = 1'b0;
        else rdy_force = 1'b1;
        foreach (line[i]) send_byte(line[i]);
        cr_edge  = last_edge;
        rdy_edge = 0;
        if (mode == 2) begin
            base = en_total;
            check_eq({tag, "/ovf_before"}, 32'(overflow), 32'(exp_ovf));
            send_byte(8'h55);
            exp_ovf = 1'b1;
            repeat (50) @(posedge clk);
            #2;
            check_eq({tag, "/no_tx_while_low"}, 32'(en_total - base), 32'd0);
            check_eq({tag, "/ovf_injected"}, 32'(overflow), 32'd1);
            rdy_force = 1'b1;
            @(posedge clk);
            #1;
            rdy_edge = cyc;
        end
        wait_idle(tag);
        rdy_rand = 1'b0;
        check_eq({tag, "/count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check_eq($sformatf("%s/byte%0d", tag, i),
                     (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        if (mode == 0 && en_cyc_q.size() > 0)
            check_eq({tag, "/latency"}, 32'(en_cyc_q[0] - cr_edge), 32'd2);
        if (mode == 2 && en_cyc_q.size() > 0)
            check_eq({tag, "/rdy_latency"}, 32'(en_cyc_q[0] - rdy_edge), 32'd1);
        check_eq({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        int n;
        int len;

        do_reset();
        @(negedge clk);
        check_eq("rst/tx_en", 32'(tx_en), 32'd0);
        check_eq("rst/tx_data", 32'(tx_data), 32'd0);
        check_eq("rst/busy", 32'(busy), 32'd0);
        check_eq("rst/overflow", 32'(overflow), 32'd0);

        q.delete(); q.push_back(8'h41); q.push_back(8'h42); q.push_back(8'h0D);
        run_line("ab_cr", q, 0);

        q.delete(); q.push_back(8'h0D);
        run_line("cr_only", q, 0);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'(8'h30 + i));
        q.push_back(8'h0D);
        run_line("fill", q, 0);

        do_reset();
        q.delete(); q.push_back(8'h31); q.push_back(8'h32); q.push_back(8'h33); q.push_back(8'h0D);
        run_line("rdy_low", q, 2);

        // Reset in the middle of a five-pulse transmission
        do_reset();
        obs_q.delete();
        rdy_force = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h61 + i));
        send_byte(8'h0D);
        n = 0;
        while (obs_q.size() < 2 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_rst/two_pulses", 32'(obs_q.size()), 32'd2);
        do_reset();
        repeat (30) @(negedge clk);
        check_eq("mid_rst/no_more_tx", 32'(obs_q.size()), 32'd2);
        check_eq("mid_rst/tx_en", 32'(tx_en), 32'd0);
        check_eq("mid_rst/tx_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst/busy", 32'(busy), 32'd0);
        check_eq("mid_rst/overflow", 32'(overflow), 32'd0);
        q.delete(); q.push_back(8'h5A); q.push_back(8'h0D);
        run_line("after_rst", q, 0);

        // Randomized lines with random tx_rdy
        do_reset();
        for (int l = 0; l < 12; l++) begin
            q.delete();
            len = $urandom_range(0, DEPTH + 3);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                while (b == 8'h0D) b = 8'($urandom_range(0, 255));
                q.push_back(b);
            end
            q.push_back(8'h0D);
            run_line($sformatf("rnd%0d", l), q, 1);
        end

        check_eq("no_back_to_back", 32'(consec_err), 32'd0);
        check_eq("tx_data_stable", 32'(stab_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
